// File: rtl/agu_pkg.sv
// agu_pkg: shared types and helpers for the address-generation stage.
//   access_size_t  : encoding of the load/store access size
//   is_misaligned  : alignment/size exception check on the low address bits
//   agu_ptr_w      : pointer width for a FIFO of a given depth
//   AGU_DEPTH, AGU_PTR_W, AGU_CNT_W : default depth and derived widths
package agu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } access_size_t;

    // Pointer width for a power-of-2 FIFO depth; never narrower than 1 bit.
    function automatic int agu_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int AGU_DEPTH = 2;
    localparam int AGU_PTR_W = agu_ptr_w(AGU_DEPTH);
    localparam int AGU_CNT_W = AGU_PTR_W + 1;

    // Byte accesses are always aligned; the reserved size always faults.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input access_size_t size);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/agu_fifo.sv
// agu_fifo: generic in-order synchronous FIFO with synchronous flush.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   flush      : clears pointers and count; discards push/pop of that cycle
//   push, wdata: write request and payload (ignored when full)
//   pop        : read request (ignored when empty)
//   rdata      : head entry payload (meaningless while empty)
//   full, empty: occupancy flags, purely from registered state
module agu_fifo
    import agu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = AGU_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = agu_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Full blocks a push even if a pop happens in the same cycle.
    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the consumer only looks at it while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/agu_pipe.sv
// agu_pipe: address-generation stage between the load/store issue queue and
// the LSQ / data-cache request port.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   flush                    : kill all buffered entries and the offered request
//   valid_in/ready_in        : issue-side handshake
//   base_in, imm_in          : effective address = base + sext(imm), wraps silently
//   size_in, store_in, tag_in: forwarded with the address
//   valid_out/ready_out      : consumer-side handshake
//   addr_out .. misalign_out : head entry, all zero while valid_out is 0
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1 and flush is 0. ready_in and valid_out come only from registered
// occupancy (no path from ready_out or valid_in). Once valid_out is raised the
// head entry is held stable until it is accepted or flushed.
module agu_pipe
    import agu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 5,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = AGU_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] base_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [1:0]        size_in,
    input  logic              store_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] addr_out,
    output logic [1:0]        size_out,
    output logic              store_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic              misalign_out
);

    localparam int PAY_W = DATA_W + 1 + 2 + 1 + TAG_W;

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] addr;
    logic              misalign;
    logic [PAY_W-1:0]  wdata;
    logic [PAY_W-1:0]  rdata;
    logic              full;
    logic              empty;

    assign imm_sext = {{(DATA_W-IMM_W){imm_in[IMM_W-1]}}, imm_in};
    assign addr     = base_in + imm_sext;
    assign misalign = is_misaligned(addr[1:0], access_size_t'(size_in));
    assign wdata    = {addr, misalign, size_in, store_in, tag_in};

    agu_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (valid_in),
        .wdata (wdata),
        .pop   (ready_out),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // ready_in is gated by rst so every output reads 0 while reset is held.
    assign ready_in  = rst & ~full;
    assign valid_out = ~empty;

    assign {addr_out, misalign_out, size_out, store_out, tag_out} =
        valid_out ? rdata : '0;

endmodule

// File: doc/agu_pipe.md
Name: agu_pipe

Overview:
Parametrised address-generation stage for the load/store path. Computes base + sign-extended immediate and checks alignment against the access size. Results are buffered in a small in-order FIFO, so the issue side and the memory/LSQ side are decoupled by valid/ready handshakes rather than a global freeze. It sits between the load/store issue queue and the LSQ/data-cache request port. It supports flush on branch mispredict or exception.

Parameters:
DATA_W, 16, address/base width in bits
IMM_W, 5, immediate width in bits, sign-extended to DATA_W
TAG_W, 5, ROB tag width
DEPTH, 2, result FIFO entries; power of 2, must be at least 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
flush  in  1  kill all in-flight and buffered entries
valid_in  in  1  request valid
ready_in  out  1  stage can accept a request
base_in  in  DATA_W  base register value
imm_in  in  IMM_W  signed offset
size_in  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved
store_in  in  1  1 = store, 0 = load
tag_in  in  TAG_W  ROB tag
valid_out  out  1  result valid
ready_out  in  1  consumer accepts result
addr_out  out  DATA_W  effective address
size_out  out  2  forwarded size
store_out  out  1  forwarded store flag
tag_out  out  TAG_W  forwarded ROB tag
misalign_out  out  1  alignment or size exception flag

Behaviour:
- Reset (rst=0, async): FIFO is emptied, read/write pointers and count are 0, all outputs are 0. ready_in is 1 after reset is released.
- Address: addr = base_in + sext(imm_in), truncated mod 2^DATA_W; the wrap-around is silent.
- misalign is 1 in any of these cases:
  - size=1 and addr[0]=1
  - size=2 and addr[1:0]!=0
  - size=3 (reserved), regardless of address
- Byte accesses (size=0) never raise misalign.
- Push: occurs on a clock edge when valid_in & ready_in & !flush. The computed address, misalign, size, store and tag are written at the write pointer.
- Pop: occurs on a clock edge when valid_out & ready_out & !flush.
- ready_in = (count != DEPTH). It depends only on registered state, with no combinational path from ready_out. A full FIFO does not accept a request even when a pop happens in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- valid_out = (count != 0). The output fields come from the head entry.
- When valid_out=0, addr_out, size_out, store_out, tag_out and misalign_out are forced to 0.
- Latency: a request accepted at edge N appears on valid_out from edge N onward (visible in cycle N+1) when the FIFO was empty. Ordering is strictly in order.
- Stall: while valid_out=1 and ready_out=0, the head entry and all output fields hold stable.
- Flush (synchronous, highest priority after reset): at the edge, count and both pointers clear to 0.
  - Any push or pop offered in that cycle is discarded.
  - The cycle after a flush has valid_out=0 and ready_in=1.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- Misaligned entries are not dropped; they flow through with misalign_out=1 so the ROB can raise the exception.

Decomposition:
- agu_pkg holds:
  - the enum access_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}
  - the function is_misaligned(addr[1:0], size)
  - the localparams for pointer and count widths derived from DEPTH
- One sub-module, agu_fifo: a generic parametrised synchronous FIFO with flush, carrying the packed {addr, misalign, size, store, tag} payload.
- agu_pipe contains the adder, the misalign check, the agu_fifo instance and the output zero-gating.

Test Plan:
- Basic: base=0x1000, imm=5'b11110 (-2), size=1, tag=3, ready_out=1 -> next cycle valid_out=1, addr_out=0x0FFE, misalign_out=0, tag_out=3, then valid_out=0.
- Wrap and alignment: base=0xFFFF, imm=1, size=2 -> addr_out=0x0000, misalign_out=0; base=0x0002, imm=0, size=2 -> misalign_out=1; size=3 at any address -> misalign_out=1; size=0 at base=0x0003 -> misalign_out=0.
- Backpressure: ready_out=0, issue tags 1, 2, 3 back to back -> tags 1 and 2 are accepted, ready_in drops to 0 after the second push, tag 3 is held. Raise ready_out -> outputs are tag 1, then 2, then 3 in order, and data stays stable while stalled.
- Simultaneous push/pop at count=1 -> count stays 1 and throughput is 1 per cycle. A full FIFO with ready_out=1 and valid_in=1 -> no push that cycle.
- Flush with the FIFO full and valid_in=1 -> next cycle valid_out=0, ready_in=1, and neither the flushed entries nor the offered entry appear later.
- Async reset asserted mid-stall with 2 entries buffered -> all outputs read 0 immediately, without waiting for a clock edge. After release, valid_out=0 and ready_in=1.
